// File: rtl/bus_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// bus_arb_pkg : shared constants and state encoding for bus_rr_arbiter
// Revision 1.0 - initial release
// ============================================================================
package bus_arb_pkg;

   localparam int          BUS_W     = 32;
   localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;

   localparam logic [0:0]  ST_IDLE   = 1'b0;
   localparam logic [0:0]  ST_BUSY   = 1'b1;

   typedef enum logic [0:0] {
      IDLE = ST_IDLE,
      BUSY = ST_BUSY
   } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/bus_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// bus_rr_arbiter_if : M-master request side plus the single shared slave port
// Revision 1.0 - initial release
// ============================================================================
interface bus_rr_arbiter_if
   import bus_arb_pkg::*;
#(
   parameter int M = 4
);
   logic [M-1:0]       m_req;
   logic [M-1:0]       m_cmd;
   logic [BUS_W*M-1:0] m_addr;
   logic [BUS_W*M-1:0] m_wdata;
   logic [M-1:0]       m_ack;
   logic [BUS_W-1:0]   m_rdata;

   logic               s_req;
   logic               s_cmd;
   logic [BUS_W-1:0]   s_addr;
   logic [BUS_W-1:0]   s_wdata;
   logic               s_ack;
   logic [BUS_W-1:0]   s_rdata;

   // master: the arbiter, which masters the slave port on behalf of the winner
   modport master (
      input  m_req, m_cmd, m_addr, m_wdata, s_ack, s_rdata,
      output m_ack, m_rdata, s_req, s_cmd, s_addr, s_wdata
   );

   modport slave (
      output m_req, m_cmd, m_addr, m_wdata, s_ack, s_rdata,
      input  m_ack, m_rdata, s_req, s_cmd, s_addr, s_wdata
   );

endinterface
`default_nettype wire

// File: rtl/bus_rr_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// rr_picker : first set request at or after rr_ptr, wrapping M-1 -> 0
// Revision 1.0 - initial release
// ============================================================================
module rr_picker #(
   parameter int M  = 4,
   parameter int PW = $clog2(M)
) (
   input  logic [M-1:0]  req,
   input  logic [PW-1:0] rr_ptr,
   output logic [M-1:0]  pick,
   output logic [PW-1:0] idx,
   output logic          any
);

   int j;

   always_comb begin
      pick = '0;
      idx  = '0;
      any  = 1'b0;
      j    = 0;
      for (int k = 0; k < M; k++) begin
         // explicit wrap keeps non-power-of-two M correct
         j = int'(rr_ptr) + k;
         if (j >= M) j = j - M;
         if (!any && req[PW'(j)]) begin
            any            = 1'b1;
            pick[PW'(j)]   = 1'b1;
            idx            = PW'(j);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/bus_rr_arbiter.sv
`default_nettype none
// ============================================================================
// bus_rr_arbiter : round-robin sharing of one slave port among M masters;
// optional hung-slave watchdog enabled by defining ARB_TIMEOUT_EN.  Rev 1.0
// ============================================================================
module bus_rr_arbiter
   import bus_arb_pkg::*;
#(
   parameter int M       = 4,
   parameter int TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             rst,
   bus_rr_arbiter_if.master bus,
   output logic [M-1:0]     grant,
   output logic             err
);

   localparam int PW = $clog2(M);

   logic [0:0]       state_q,   state_d;
   logic [M-1:0]     grant_q,   grant_d;
   logic [PW-1:0]    owner_q,   owner_d;
   logic [PW-1:0]    rr_ptr_q,  rr_ptr_d;
   logic             s_req_q,   s_req_d;
   logic             s_cmd_q,   s_cmd_d;
   logic [BUS_W-1:0] s_addr_q,  s_addr_d;
   logic [BUS_W-1:0] s_wdata_q, s_wdata_d;

   logic [M-1:0]     pick;
   logic [PW-1:0]    pick_idx;
   logic             pick_any;
   logic [PW-1:0]    owner_inc;
   logic             done;
   logic             timeout_hit;
   logic [BUS_W-1:0] m_addr_arr  [M];
   logic [BUS_W-1:0] m_wdata_arr [M];

`ifdef ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0]    cnt_q, cnt_d;
`else
   logic             unused_timeout;
   assign unused_timeout = (TIMEOUT != 0);
`endif

   for (genvar i = 0; i < M; i++) begin : g_unpack
      assign m_addr_arr[i]  = bus.m_addr[BUS_W*i +: BUS_W];
      assign m_wdata_arr[i] = bus.m_wdata[BUS_W*i +: BUS_W];
   end

   rr_picker #(
      .M  (M),
      .PW (PW)
   ) u_picker (
      .req    (bus.m_req),
      .rr_ptr (rr_ptr_q),
      .pick   (pick),
      .idx    (pick_idx),
      .any    (pick_any)
   );

   assign owner_inc = (owner_q == PW'(M - 1)) ? '0 : owner_q + PW'(1);

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      owner_d     = owner_q;
      rr_ptr_d    = rr_ptr_q;
      s_req_d     = s_req_q;
      s_cmd_d     = s_cmd_q;
      s_addr_d    = s_addr_q;
      s_wdata_d   = s_wdata_q;
      done        = 1'b0;
      timeout_hit = 1'b0;
      bus.m_ack   = '0;
      bus.m_rdata = '0;
`ifdef ARB_TIMEOUT_EN
      cnt_d       = cnt_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (pick_any) begin
               state_d   = ST_BUSY;
               grant_d   = pick;
               owner_d   = pick_idx;
               s_req_d   = 1'b1;
               s_cmd_d   = bus.m_cmd[pick_idx];
               s_addr_d  = m_addr_arr[pick_idx];
               s_wdata_d = m_wdata_arr[pick_idx];
`ifdef ARB_TIMEOUT_EN
               cnt_d     = CW'(1);
`endif
            end
         end
         ST_BUSY: begin
            // a real completion beats a watchdog expiry in the same cycle
            if (bus.s_ack) begin
               done        = 1'b1;
               bus.m_rdata = bus.s_rdata;
            end
`ifdef ARB_TIMEOUT_EN
            else if (cnt_q == CW'(TIMEOUT)) begin
               done        = 1'b1;
               timeout_hit = 1'b1;
               bus.m_rdata = ERR_RDATA;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
`endif
            if (done) begin
               bus.m_ack = grant_q;
               state_d   = ST_IDLE;
               grant_d   = '0;
               s_req_d   = 1'b0;
               rr_ptr_d  = owner_inc;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         grant_q   <= '0;
         owner_q   <= '0;
         rr_ptr_q  <= '0;
         s_req_q   <= 1'b0;
         s_cmd_q   <= 1'b0;
         s_addr_q  <= '0;
         s_wdata_q <= '0;
`ifdef ARB_TIMEOUT_EN
         cnt_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         owner_q   <= owner_d;
         rr_ptr_q  <= rr_ptr_d;
         s_req_q   <= s_req_d;
         s_cmd_q   <= s_cmd_d;
         s_addr_q  <= s_addr_d;
         s_wdata_q <= s_wdata_d;
`ifdef ARB_TIMEOUT_EN
         cnt_q     <= cnt_d;
`endif
      end
   end

   assign grant       = grant_q;
   assign err         = timeout_hit;
   assign bus.s_req   = s_req_q;
   assign bus.s_cmd   = s_cmd_q;
   assign bus.s_addr  = s_addr_q;
   assign bus.s_wdata = s_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_rr_arbiter.sv
`default_nettype none
// ============================================================================
// tb_bus_rr_arbiter : directed + randomized bench with a round-robin reference
// Revision 1.0 - initial release
// ============================================================================
module tb_bus_rr_arbiter;
   import bus_arb_pkg::*;

   localparam int M       = 4;
   localparam int TIMEOUT = 16;

   logic         clk = 1'b0;
   logic         rst;
   logic [M-1:0] grant;
   logic         err;

   int vectors     = 0;
   int miscompares = 0;
   int last_served;

   bus_rr_arbiter_if #(.M(M)) bus ();

   bus_rr_arbiter #(
      .M       (M),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .bus   (bus),
      .grant (grant),
      .err   (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: the next winner is the first requester after the last one served.
   function automatic int pick_next(input logic [M-1:0] req);
      for (int k = 1; k <= M; k++) begin
         int i = (last_served + k) % M;
         if (req[i]) return i;
      end
      return -1;
   endfunction

   task automatic set_master(input int i, input logic cmd, input logic [31:0] addr,
                             input logic [31:0] wdata);
      bus.m_cmd[i]             = cmd;
      bus.m_addr[32*i +: 32]   = addr;
      bus.m_wdata[32*i +: 32]  = wdata;
   endtask

   task automatic randomize_masters();
      for (int i = 0; i < M; i++)
         set_master(i, 1'($urandom_range(0, 1)), $urandom, $urandom);
   endtask

   // Called with the DUT idle and m_req already set; returns with the DUT idle again.
   task automatic run_txn(input int lat, input logic [31:0] rdata, input bit keep);
      int          w;
      logic        ecmd;
      logic [31:0] eaddr, ewdata;
      w = pick_next(bus.m_req);
      if (w < 0) w = 0;
      ecmd   = bus.m_cmd[w];
      eaddr  = bus.m_addr[32*w +: 32];
      ewdata = bus.m_wdata[32*w +: 32];
      tick();
      bus.s_ack = 1'b0;
      #1;
      chk("s_req_up",  32'(bus.s_req), 32'd1);
      chk("grant",     32'(grant),     32'(1 << w));
      chk("s_cmd",     32'(bus.s_cmd), 32'(ecmd));
      chk("s_addr",    bus.s_addr,     eaddr);
      chk("s_wdata",   bus.s_wdata,    ewdata);
      for (int c = 0; c < lat; c++) begin
         set_master(w, ~ecmd, $urandom, $urandom);
         tick();
         chk("m_ack_wait",   32'(bus.m_ack), 32'd0);
         chk("m_rdata_wait", bus.m_rdata,    32'd0);
         chk("s_addr_hold",  bus.s_addr,     eaddr);
         chk("err_quiet",    32'(err),       32'd0);
      end
      bus.s_rdata = rdata;
      bus.s_ack   = 1'b1;
      #1;
      chk("m_ack",   32'(bus.m_ack), 32'(1 << w));
      chk("m_rdata", bus.m_rdata,    rdata);
      tick();
      bus.s_ack = 1'($urandom_range(0, 1));
      if (!keep) bus.m_req[w] = 1'b0;
      #1;
      chk("grant_clear", 32'(grant),       32'd0);
      chk("s_req_clear", 32'(bus.s_req),   32'd0);
      chk("m_ack_idle",  32'(bus.m_ack),   32'd0);
      chk("rdata_idle",  bus.m_rdata,      32'd0);
      last_served = w;
   endtask

   initial begin
      rst         = 1'b1;
      bus.m_req   = '0;
      bus.m_cmd   = '0;
      bus.m_addr  = '0;
      bus.m_wdata = '0;
      bus.s_ack   = 1'b0;
      bus.s_rdata = '0;
      last_served = M - 1;
      #2 rst = 1'b0;
      #1;
      chk("rst_s_req",   32'(bus.s_req),   32'd0);
      chk("rst_s_cmd",   32'(bus.s_cmd),   32'd0);
      chk("rst_s_addr",  bus.s_addr,       32'd0);
      chk("rst_s_wdata", bus.s_wdata,      32'd0);
      chk("rst_grant",   32'(grant),       32'd0);
      chk("rst_m_ack",   32'(bus.m_ack),   32'd0);
      chk("rst_m_rdata", bus.m_rdata,      32'd0);
      chk("rst_err",     32'(err),         32'd0);
      tick();
      tick();
      rst = 1'b1;

      // single master write, slave answers in the third busy cycle
      set_master(2, 1'b1, 32'h0000_0CE2, 32'h0000_0345);
      bus.m_req = 4'b0100;
      run_txn(2, $urandom, 1'b0);

      // randomized traffic
      for (int n = 0; n < 24; n++) begin
         randomize_masters();
         bus.m_req = 4'($urandom_range(1, 15));
         run_txn(int'($urandom_range(0, 4)), $urandom, 1'($urandom_range(0, 1)));
      end

      // reset while busy aborts the transaction without an ack
      bus.s_ack = 1'b0;
      bus.m_req = 4'b0010;
      tick();
      chk("pre_rst_grant", 32'(grant), 32'd2);
      bus.s_ack = 1'b1;
      rst       = 1'b0;
      #1;
      chk("midrst_s_req",  32'(bus.s_req), 32'd0);
      chk("midrst_grant",  32'(grant),     32'd0);
      chk("midrst_m_ack",  32'(bus.m_ack), 32'd0);
      chk("midrst_rdata",  bus.m_rdata,    32'd0);
      tick();
      bus.s_ack   = 1'b0;
      rst         = 1'b1;
      last_served = M - 1;

      // all masters hold requests: served 0,1,2,3,0,1
      randomize_masters();
      bus.m_req = 4'b1111;
      for (int n = 0; n < 6; n++)
         run_txn(int'($urandom_range(0, 3)), $urandom, 1'b1);

      // rotation with gaps: serve 3, then 1 and 3 contend -> 1 first
      bus.m_req = 4'b1000;
      run_txn(0, $urandom, 1'b0);
      bus.m_req = 4'b1010;
      run_txn(1, $urandom, 1'b0);
      run_txn(1, $urandom, 1'b0);

      // read return for master 0
      set_master(0, 1'b0, $urandom, $urandom);
      bus.m_req = 4'b0001;
      run_txn(1, 32'h1234_5678, 1'b0);

`ifdef ARB_TIMEOUT_EN
      begin
         int w, w2;
         bus.s_ack = 1'b0;
         randomize_masters();
         bus.m_req = 4'b0011;
         w = pick_next(bus.m_req);
         tick();
         chk("to_grant", 32'(grant), 32'(1 << w));
         for (int c = 1; c <= TIMEOUT; c++) begin
            if (c < TIMEOUT) begin
               chk("to_ack_early", 32'(bus.m_ack), 32'd0);
               chk("to_err_early", 32'(err),       32'd0);
               tick();
            end
         end
         chk("to_m_ack",  32'(bus.m_ack), 32'(1 << w));
         chk("to_rdata",  bus.m_rdata,    ERR_RDATA);
         chk("to_err",    32'(err),       32'd1);
         bus.m_req[w] = 1'b0;
         last_served  = w;
         tick();
         chk("to_err_pulse",  32'(err),   32'd0);
         chk("to_grant_idle", 32'(grant), 32'd0);
         w2 = pick_next(bus.m_req);
         tick();
         chk("to_next_grant", 32'(grant), 32'(1 << w2));
         bus.s_ack = 1'b1;
         #1;
         chk("to_next_ack", 32'(bus.m_ack), 32'(1 << w2));
         tick();
         bus.s_ack   = 1'b0;
         bus.m_req   = '0;
         last_served = w2;
      end
`else
      // without the watchdog a silent slave simply keeps the owner waiting
      randomize_masters();
      bus.m_req = 4'b0100;
      run_txn(20, $urandom, 1'b0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1, "time limit");
   end

endmodule
`default_nettype wire
